scarf_bram_wide: RTL and testbench
==================================

Name: scarf_bram_wide

Overview:
- Parametrised SCARF slave bridging the UART byte stream to a block RAM of configurable address width, word width and read latency.
- Successor to the single-byte, 13-bit BRAM slave. Adds:
  - multi-byte words;
  - N-byte addresses;
  - wrap or saturate address mode;
  - latency-aware read prefetch;
  - a sticky address-limit status flag.
- Sits between the SCARF UART decoder (byte stream, slave_id, rnw, finished) and a simple-dual-port BRAM.

Parameters:
- SLAVE_ID, 7'h02, ID this slave answers to.
- ADDR_WIDTH, 13, BRAM word-address width (1..32).
- DATA_BYTES, 1, bytes per BRAM word (1..4). Bytes are transferred MSB first.
- RD_LATENCY, 1, cycles from bram_ren to valid bram_read_data (1..3).
- MAX_ADDRESS, 2**ADDR_WIDTH-1, highest legal word address.
- WRAP_EN, 0, address behaviour at MAX_ADDRESS:
  - 1: wrap to 0.
  - 0: hold at MAX_ADDRESS and drop further accesses.
- Derived localparam ADDR_BYTES = ceil(ADDR_WIDTH/8).

Ports:
- clk  in  1  system clock
- rst_sync  in  1  asynchronous, active-high reset
- data_in  in  8  byte from UART decoder
- data_in_valid  in  1  one-cycle strobe per byte
- data_in_finished  in  1  one-cycle strobe, end of transaction
- slave_id  in  7  target ID of current transaction
- rnw  in  1  1=read, 0=write; stable for the whole transaction
- read_data_out  out  8  byte returned to UART for next position
- bram_read_data  in  8*DATA_BYTES  BRAM read word
- bram_write_data  out  8*DATA_BYTES  BRAM write word
- bram_addr  out  ADDR_WIDTH  BRAM word address
- bram_wen  out  1  one-cycle write strobe
- bram_ren  out  1  one-cycle read strobe
- addr_limit  out  1  sticky: an access was dropped at MAX_ADDRESS (WRAP_EN=0)

Behaviour:
- Reset values: all outputs 0; FSM in ADDR; byte counters 0; word buffer 0.
- Gating:
  - valid_slave = (slave_id==SLAVE_ID). Bytes are only acted on when valid_slave && data_in_valid.
  - data_in_finished takes priority over everything: return to ADDR, counters 0, bram_addr 0, no strobe issued that cycle.
  - addr_limit is not cleared by data_in_finished; it clears only on reset or at the first address byte of a new valid-slave transaction.
- State ADDR:
  - Collects ADDR_BYTES bytes, MSB first, into bram_addr. Bits above ADDR_WIDTH in the top byte are discarded.
  - After the last address byte: rnw=0 → WDATA; rnw=1 → RFETCH.
- State WDATA:
  - Shifts DATA_BYTES bytes into bram_write_data.
  - On the last byte of a word, the next cycle pulses bram_wen for one cycle with the complete word and the current bram_addr. The cycle after that, bram_addr advances.
  - A partial word at finished is discarded; no write occurs.
- State RFETCH:
  - Pulses bram_ren one cycle at bram_addr.
  - Captures bram_read_data exactly RD_LATENCY cycles after bram_ren, then → RDATA.
- State RDATA:
  - read_data_out = buffer byte at index byte_idx (MSB first).
  - Each valid byte advances byte_idx. After byte DATA_BYTES-1, bram_addr advances and the FSM → RFETCH (prefetch of next word).
  - Upstream guarantees data_in_valid spacing >= RD_LATENCY+3 clk; the bench must respect this.
- Address advance:
  - If bram_addr != MAX_ADDRESS: increment.
  - Else, WRAP_EN=1: go to 0.
  - Else, WRAP_EN=0: hold, set addr_limit. In that case further writes and reads in this transaction are suppressed (no wen/ren) and read_data_out is 8'h00.
- read_data_out priority:
  1. !valid_slave → 8'h00.
  2. In ADDR before any byte → {1'b0,SLAVE_ID}.
  3. During address bytes → 8'h00.
  4. RDATA → buffer byte.
- bram_wen and bram_ren are never asserted in the same cycle. Neither is asserted while !valid_slave.
- A write transaction never asserts bram_ren. Read data is never written.

Test Plan:
- Write, DATA_BYTES=2, ADDR_WIDTH=13. Bytes 8'h01,8'h23,8'hAB,8'hCD,8'h12,8'h34 → bram_wen twice: addr 13'h0123 data 16'hABCD, then addr 13'h0124 data 16'h1234. No bram_ren.
- Read, DATA_BYTES=2, RD_LATENCY=2, BRAM[0x10]=16'hBEEF, BRAM[0x11]=16'hCAFE. Addr 8'h00,8'h10 then 4 dummy bytes → read_data_out sequence EF? no: BE,EF,CA,FE (MSB first). bram_ren pulses at 0x10 then 0x11.
- Saturate, WRAP_EN=0, write at 13'h1FFF with 3 words → one bram_wen at 0x1FFF, addr_limit=1, no further wen. addr_limit survives finished and clears on the next address byte.
- Wrap, WRAP_EN=1, read starting at 13'h1FFF for 2 words → bram_ren at 0x1FFF then 0x0000; addr_limit stays 0.
- Foreign slave_id=7'h05 with valid bytes → no strobes, read_data_out=0. Partial write (1 of 2 data bytes) then finished → no bram_wen, bram_addr=0.
- rst_sync asserted mid-read between bram_ren and capture → all outputs 0 immediately (asynchronous). After release, a new transaction behaves normally with no stale capture.

Source files
------------

// File: rtl/scarf_bram_wide.sv
// SCARF slave bridging the UART byte stream to a simple-dual-port block RAM with
// multi-byte words, multi-byte addresses, wrap/saturate addressing and read prefetch.
module scarf_bram_wide #(
    parameter logic [6:0]            SLAVE_ID    = 7'h02,
    parameter int unsigned           ADDR_WIDTH  = 13,
    parameter int unsigned           DATA_BYTES  = 1,
    parameter int unsigned           RD_LATENCY  = 1,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDRESS = {ADDR_WIDTH{1'b1}},
    parameter bit                    WRAP_EN     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_sync,
    input  logic [7:0]              data_in,
    input  logic                    data_in_valid,
    input  logic                    data_in_finished,
    input  logic [6:0]              slave_id,
    input  logic                    rnw,
    output logic [7:0]              read_data_out,
    input  logic [8*DATA_BYTES-1:0] bram_read_data,
    output logic [8*DATA_BYTES-1:0] bram_write_data,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic                    bram_wen,
    output logic                    bram_ren,
    output logic                    addr_limit
);

    localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int unsigned DW         = 8 * DATA_BYTES;
    localparam int unsigned ACW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int unsigned BIW        = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [1:0] {StAddr, StWdata, StRfetch, StRdata} state_e;

    state_e                  state_q, state_d;
    logic [ACW-1:0]          addr_cnt_q, addr_cnt_d;
    logic [BIW-1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic [DW-1:0]           rbuf_q, rbuf_d;
    logic [1:0]              lat_q, lat_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;
    logic                    drop_q, drop_d;
    logic                    limit_q, limit_d;
    logic [7:0]              rdo_q, rdo_d;
    logic                    valid_slave, byte_ok, adv, at_limit;

    assign valid_slave = (slave_id == SLAVE_ID);
    assign byte_ok     = valid_slave && data_in_valid;
    assign at_limit    = (addr_q == MAX_ADDRESS) && !WRAP_EN;

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        lat_d      = lat_q;
        drop_d     = drop_q;
        limit_d    = limit_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        adv        = 1'b0;
        rdo_d      = 8'h00;

        if (data_in_finished) begin
            state_d    = StAddr;
            addr_cnt_d = '0;
            byte_idx_d = '0;
            addr_d     = '0;
            lat_d      = '0;
            drop_d     = 1'b0;
        end else begin
            // The address moves on the cycle after the write strobe.
            adv = wen_q;
            unique case (state_q)
                StAddr: begin
                    if (byte_ok) begin
                        addr_d = ADDR_WIDTH'({addr_q, data_in});
                        if (addr_cnt_q == '0) begin
                            limit_d = 1'b0;
                            drop_d  = 1'b0;
                        end
                        if (addr_cnt_q == ACW'(ADDR_BYTES - 1)) begin
                            addr_cnt_d = '0;
                            lat_d      = '0;
                            if (rnw) begin
                                state_d = StRfetch;
                                ren_d   = 1'b1;
                            end else begin
                                state_d = StWdata;
                            end
                        end else begin
                            addr_cnt_d = addr_cnt_q + ACW'(1);
                        end
                    end
                end
                StWdata: begin
                    if (byte_ok) begin
                        wdata_d = DW'({wdata_q, data_in});
                        if (byte_idx_q == BIW'(DATA_BYTES - 1)) begin
                            byte_idx_d = '0;
                            wen_d      = !drop_q;
                        end else begin
                            byte_idx_d = byte_idx_q + BIW'(1);
                        end
                    end
                end
                StRfetch: begin
                    if (lat_q == 2'(RD_LATENCY)) begin
                        if (!drop_q) rbuf_d = bram_read_data;
                        state_d = StRdata;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                StRdata: begin
                    if (byte_ok) begin
                        if (byte_idx_q == BIW'(DATA_BYTES - 1)) begin
                            byte_idx_d = '0;
                            adv        = 1'b1;
                            lat_d      = '0;
                            state_d    = StRfetch;
                            ren_d      = !drop_q && !at_limit;
                        end else begin
                            byte_idx_d = byte_idx_q + BIW'(1);
                        end
                    end
                end
                default: state_d = StAddr;
            endcase

            if (adv) begin
                if (addr_q != MAX_ADDRESS) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end else if (WRAP_EN) begin
                    addr_d = '0;
                end else begin
                    limit_d = 1'b1;
                    drop_d  = 1'b1;
                end
            end
        end

        // Output byte is registered from next-state values so it tracks the FSM without lag.
        if (valid_slave) begin
            if (state_d == StAddr && addr_cnt_d == '0) begin
                rdo_d = {1'b0, SLAVE_ID};
            end else if (state_d == StRdata && !drop_d) begin
                for (int i = 0; i < DATA_BYTES; i++) begin
                    if (byte_idx_d == BIW'(i)) rdo_d = rbuf_d[DW-8-8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_q    <= StAddr;
            addr_cnt_q <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            lat_q      <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            drop_q     <= 1'b0;
            limit_q    <= 1'b0;
            rdo_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            lat_q      <= lat_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            drop_q     <= drop_d;
            limit_q    <= limit_d;
            rdo_q      <= rdo_d;
        end
    end

    assign read_data_out   = rdo_q;
    assign bram_write_data = wdata_q;
    assign bram_addr       = addr_q;
    assign bram_wen        = wen_q && valid_slave;
    assign bram_ren        = ren_q && valid_slave;
    assign addr_limit      = limit_q;

endmodule

// File: tb/tb_scarf_bram_wide.sv
// Directed bench for scarf_bram_wide: one saturating and one wrapping instance
// sharing the UART-side stimulus, each with its own latency-2 BRAM model.
module tb_scarf_bram_wide;

    logic        clk;
    logic        rst_sync;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_finished;
    logic [6:0]  slave_id;
    logic        rnw;

    logic [7:0]  rdo, rdo_w;
    logic [15:0] wdata, wdata_w;
    logic [12:0] addr, addr_w;
    logic        wen, wen_w, ren, ren_w, limit, limit_w;
    logic [15:0] bram_rd, bram_rd_w;

    logic [15:0] mem   [0:8191];
    logic [15:0] mem_w [0:8191];
    logic [15:0] s1, s2, s1_w, s2_w;

    logic [12:0] wen_a[$];
    logic [15:0] wen_dq[$];
    logic [12:0] ren_a[$];
    logic [12:0] renw_a[$];

    int checks = 0;
    int errors = 0;

    scarf_bram_wide #(
        .SLAVE_ID(7'h02), .ADDR_WIDTH(13), .DATA_BYTES(2), .RD_LATENCY(2),
        .MAX_ADDRESS(13'h1FFF), .WRAP_EN(1'b0)
    ) dut (
        .clk(clk), .rst_sync(rst_sync), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
        .read_data_out(rdo), .bram_read_data(bram_rd), .bram_write_data(wdata),
        .bram_addr(addr), .bram_wen(wen), .bram_ren(ren), .addr_limit(limit)
    );

    scarf_bram_wide #(
        .SLAVE_ID(7'h02), .ADDR_WIDTH(13), .DATA_BYTES(2), .RD_LATENCY(2),
        .MAX_ADDRESS(13'h1FFF), .WRAP_EN(1'b1)
    ) dut_w (
        .clk(clk), .rst_sync(rst_sync), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
        .read_data_out(rdo_w), .bram_read_data(bram_rd_w), .bram_write_data(wdata_w),
        .bram_addr(addr_w), .bram_wen(wen_w), .bram_ren(ren_w), .addr_limit(limit_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data is driven only in the exact cycle RD_LATENCY=2 after the strobe, zero otherwise.
    always @(posedge clk) begin
        s1   <= ren ? mem[addr] : 16'h0000;
        s2   <= s1;
        s1_w <= ren_w ? mem_w[addr_w] : 16'h0000;
        s2_w <= s1_w;
    end
    assign bram_rd   = s2;
    assign bram_rd_w = s2_w;

    always @(negedge clk) begin
        if (wen) begin
            wen_a.push_back(addr);
            wen_dq.push_back(wdata);
        end
        if (ren) ren_a.push_back(addr);
        if (ren_w) renw_a.push_back(addr_w);
        if (wen || ren) begin
            checks++;
            if ((wen && ren) || slave_id != 7'h02) begin
                errors++;
                $display("FAIL strobe_rules: wen=%b ren=%b slave_id=%h required exclusive, id 02",
                         wen, ren, slave_id);
            end
        end
    end

    task automatic clear_q();
        wen_a.delete();
        wen_dq.delete();
        ren_a.delete();
        renw_a.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic finish_txn();
        data_in_finished = 1'b1;
        @(negedge clk);
        data_in_finished = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({rdo, wdata, addr, wen, ren, limit} !== 40'h0) begin
            errors++;
            $display("FAIL %s: rdo=%h wdata=%h addr=%h wen=%b ren=%b limit=%b required all 0",
                     name, rdo, wdata, addr, wen, ren, limit);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst_sync = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdo !== 8'h02) begin
            errors++;
            $display("FAIL idle_slave_id: got %h required %h", rdo, 8'h02);
        end
    endtask

    task automatic test_write();
        rnw = 1'b0;
        clear_q();
        send_byte(8'h01);
        checks++;
        if (rdo !== 8'h00) begin
            errors++;
            $display("FAIL addr_byte_rdo: got %h required 00", rdo);
        end
        send_byte(8'h23);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if (wen_a.size() != 2 || ren_a.size() != 0) begin
            errors++;
            $display("FAIL wr_strobes: got wen=%0d ren=%0d required 2 and 0",
                     wen_a.size(), ren_a.size());
        end
        checks++;
        if (wen_a[0] !== 13'h0123 || wen_dq[0] !== 16'hABCD) begin
            errors++;
            $display("FAIL wr_word0: got %h@%h required abcd@0123", wen_dq[0], wen_a[0]);
        end
        checks++;
        if (wen_a[1] !== 13'h0124 || wen_dq[1] !== 16'h1234) begin
            errors++;
            $display("FAIL wr_word1: got %h@%h required 1234@0124", wen_dq[1], wen_a[1]);
        end
        finish_txn();
        checks++;
        if (addr !== 13'h0000) begin
            errors++;
            $display("FAIL wr_finish_addr: got %h required 0000", addr);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [4];
        exp = '{8'hBE, 8'hEF, 8'hCA, 8'hFE};
        mem[13'h010] = 16'hBEEF;
        mem[13'h011] = 16'hCAFE;
        rnw = 1'b1;
        clear_q();
        send_byte(8'h00);
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdo !== exp[i]) begin
                errors++;
                $display("FAIL rd_byte%0d: got %h required %h", i, rdo, exp[i]);
            end
            send_byte(8'h00);
        end
        checks++;
        if (ren_a.size() < 2 || ren_a[0] !== 13'h010 || ren_a[1] !== 13'h011) begin
            errors++;
            $display("FAIL rd_ren_addrs: got n=%0d %h,%h required 0010,0011",
                     ren_a.size(), ren_a[0], ren_a[1]);
        end
        checks++;
        if (wen_a.size() != 0) begin
            errors++;
            $display("FAIL rd_no_wen: got %0d required 0", wen_a.size());
        end
        finish_txn();
    endtask

    task automatic test_saturate();
        rnw = 1'b0;
        clear_q();
        send_byte(8'h1F);
        send_byte(8'hFF);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        checks++;
        if (wen_a.size() != 1 || wen_a[0] !== 13'h1FFF || wen_dq[0] !== 16'h1122) begin
            errors++;
            $display("FAIL sat_writes: got n=%0d %h@%h required 1 x 1122@1fff",
                     wen_a.size(), wen_dq[0], wen_a[0]);
        end
        checks++;
        if (limit !== 1'b1 || addr !== 13'h1FFF) begin
            errors++;
            $display("FAIL sat_limit: got limit=%b addr=%h required 1, 1fff", limit, addr);
        end
        finish_txn();
        checks++;
        if (limit !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: got %b required 1", limit);
        end
        send_byte(8'h00);
        checks++;
        if (limit !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %b required 0", limit);
        end
        finish_txn();
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        mem_w[13'h1FFF] = 16'hA1B2;
        mem_w[13'h0000] = 16'hC3D4;
        rnw = 1'b1;
        clear_q();
        send_byte(8'h1F);
        send_byte(8'hFF);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdo_w !== exp[i]) begin
                errors++;
                $display("FAIL wrap_byte%0d: got %h required %h", i, rdo_w, exp[i]);
            end
            if (i == 2) begin
                checks++;
                if (rdo !== 8'h00 || limit !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_read_drop: got rdo=%h limit=%b required 00, 1", rdo, limit);
                end
            end
            send_byte(8'h00);
        end
        checks++;
        if (renw_a.size() < 2 || renw_a[0] !== 13'h1FFF || renw_a[1] !== 13'h0000) begin
            errors++;
            $display("FAIL wrap_ren_addrs: got n=%0d %h,%h required 1fff,0000",
                     renw_a.size(), renw_a[0], renw_a[1]);
        end
        checks++;
        if (limit_w !== 1'b0 || ren_a.size() != 1) begin
            errors++;
            $display("FAIL wrap_limit: got limit_w=%b sat_ren=%0d required 0, 1",
                     limit_w, ren_a.size());
        end
        finish_txn();
    endtask

    task automatic test_foreign();
        rnw = 1'b0;
        slave_id = 7'h05;
        clear_q();
        repeat (2) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        checks++;
        if (wen_a.size() != 0 || ren_a.size() != 0 || rdo !== 8'h00) begin
            errors++;
            $display("FAIL foreign: got wen=%0d ren=%0d rdo=%h required 0,0,00",
                     wen_a.size(), ren_a.size(), rdo);
        end
        slave_id = 7'h02;
        finish_txn();
    endtask

    task automatic test_partial();
        rnw = 1'b0;
        clear_q();
        send_byte(8'h00);
        send_byte(8'h20);
        checks++;
        if (addr !== 13'h0020) begin
            errors++;
            $display("FAIL partial_addr: got %h required 0020", addr);
        end
        send_byte(8'hAB);
        finish_txn();
        checks++;
        if (wen_a.size() != 0 || addr !== 13'h0000 || rdo !== 8'h02) begin
            errors++;
            $display("FAIL partial_drop: got wen=%0d addr=%h rdo=%h required 0,0000,02",
                     wen_a.size(), addr, rdo);
        end
    endtask

    task automatic test_reset_mid_read();
        mem[13'h040] = 16'h5A6B;
        rnw = 1'b1;
        send_byte(8'h00);
        data_in       = 8'h40;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        checks++;
        if (ren !== 1'b1 || addr !== 13'h0040) begin
            errors++;
            $display("FAIL mid_ren: got ren=%b addr=%h required 1, 0040", ren, addr);
        end
        @(negedge clk);
        rst_sync = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (4) @(negedge clk);
        rst_sync = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (rdo !== 8'h02 || addr !== 13'h0000) begin
            errors++;
            $display("FAIL post_reset: got rdo=%h addr=%h required 02, 0000", rdo, addr);
        end
        clear_q();
        send_byte(8'h00);
        send_byte(8'h11);
        checks++;
        if (rdo !== 8'hCA) begin
            errors++;
            $display("FAIL post_reset_rd0: got %h required ca", rdo);
        end
        send_byte(8'h00);
        checks++;
        if (rdo !== 8'hFE || ren_a.size() != 1 || ren_a[0] !== 13'h011) begin
            errors++;
            $display("FAIL post_reset_rd1: got %h n=%0d @%h required fe, 1 @0011",
                     rdo, ren_a.size(), ren_a[0]);
        end
        finish_txn();
    endtask

    initial begin
        rst_sync         = 1'b1;
        data_in          = 8'h00;
        data_in_valid    = 1'b0;
        data_in_finished = 1'b0;
        slave_id         = 7'h02;
        rnw              = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_saturate();
        test_wrap();
        test_foreign();
        test_partial();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
